// File: rtl/irq_prio_ctrl4_if.sv
// Request/handshake bundle between the interrupt sources, the controller and the index consumer.
// The master side drives requests, mask and ack; the slave (controller) drives the selection results.
interface irq_prio_ctrl4_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       irq_in;
  logic [3:0]       mask;
  logic             irq_ack;
  logic             irq_valid;
  logic [1:0]       irq_id;
  logic [3:0]       pending;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output irq_in,
    output mask,
    output irq_ack,
    input  irq_valid,
    input  irq_id,
    input  pending,
    input  drop_cnt
  );

  modport slave (
    input  irq_in,
    input  mask,
    input  irq_ack,
    output irq_valid,
    output irq_id,
    output pending,
    output drop_cnt
  );
endinterface

// File: rtl/irq_prio_ctrl4.sv
// 4-input interrupt controller: edge/level capture into pending, mask, fixed priority (3 high), valid/ack index.
// Latency 2 cycles request->irq_valid; index held until irq_ack, then at least one idle cycle before the next grant.
module irq_prio_ctrl4 #(
  parameter int EDGE_MODE = 1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  irq_prio_ctrl4_if.slave   bus
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t           r_state;
  logic [3:0]       r_irq_prev;
  logic [3:0]       r_pending;
  logic [1:0]       r_irq_id;
  logic [CNT_W-1:0] r_drop_cnt;

  state_t           w_state_nxt;
  logic [1:0]       w_irq_id_nxt;
  logic [3:0]       w_set;
  logic [3:0]       w_clr;
  logic             w_ack;
  logic             w_collide;
  logic [3:0]       w_eligible;
  logic [1:0]       w_winner;

  assign w_set      = (EDGE_MODE != 0) ? (bus.irq_in & ~r_irq_prev) : bus.irq_in;
  // Ack only counts while an index is actually being presented.
  assign w_ack      = (r_state == ST_PRESENT) && bus.irq_ack;
  assign w_clr      = w_ack ? (4'b0001 << r_irq_id) : 4'b0000;
  assign w_collide  = |(w_set & r_pending & ~w_clr);
  assign w_eligible = r_pending & ~bus.mask;

  always_comb begin
    w_winner = 2'd0;
    if (w_eligible[3]) begin
      w_winner = 2'd3;
    end else if (w_eligible[2]) begin
      w_winner = 2'd2;
    end else if (w_eligible[1]) begin
      w_winner = 2'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_irq_id_nxt = r_irq_id;
    case (r_state)
      ST_IDLE: begin
        if (|w_eligible) begin
          w_state_nxt  = ST_PRESENT;
          w_irq_id_nxt = w_winner;
        end
      end
      ST_PRESENT: begin
        if (bus.irq_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_irq_prev <= 4'b0000;
      r_pending  <= 4'b0000;
      r_irq_id   <= 2'd0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_irq_prev <= bus.irq_in;
      // Set is applied after clear so a new request on the acked bit survives.
      r_pending  <= (r_pending & ~w_clr) | w_set;
      r_irq_id   <= w_irq_id_nxt;
      if (w_collide && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.irq_valid = (r_state == ST_PRESENT);
  assign bus.irq_id    = r_irq_id;
  assign bus.pending   = r_pending;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule
